// File: rtl/iob_regfile_2p_arbiter_if.sv
// Bundles the requester-side and register-file-side buses of iob_regfile_2p_arbiter.
// slave modport: the arbiter's view. master modport: the clients/register-file view.
// Signal names keep the arbiter port names so waveforms match the block documentation.
interface iob_regfile_2p_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 21
);
  // requester write channel
  logic [N_REQ-1:0]        req_wvalid_i;
  logic [N_REQ*ADDR_W-1:0] req_waddr_i;
  logic [N_REQ*DATA_W-1:0] req_wdata_i;
  logic [N_REQ-1:0]        req_wready_o;
  // requester read channel
  logic [N_REQ-1:0]        req_rvalid_i;
  logic [N_REQ*ADDR_W-1:0] req_raddr_i;
  logic [N_REQ-1:0]        req_rready_o;
  logic [N_REQ-1:0]        req_rdvalid_o;
  logic [DATA_W-1:0]       req_rdata_o;
  // register file ports
  logic                    rf_wen_o;
  logic [ADDR_W-1:0]       rf_waddr_o;
  logic [DATA_W-1:0]       rf_wdata_o;
  logic [ADDR_W-1:0]       rf_raddr_o;
  logic [DATA_W-1:0]       rf_rdata_i;

  modport slave (
    input  req_wvalid_i, req_waddr_i, req_wdata_i, req_rvalid_i, req_raddr_i, rf_rdata_i,
    output req_wready_o, req_rready_o, req_rdvalid_o, req_rdata_o,
           rf_wen_o, rf_waddr_o, rf_wdata_o, rf_raddr_o
  );

  modport master (
    output req_wvalid_i, req_waddr_i, req_wdata_i, req_rvalid_i, req_raddr_i, rf_rdata_i,
    input  req_wready_o, req_rready_o, req_rdvalid_o, req_rdata_o,
           rf_wen_o, rf_waddr_o, rf_wdata_o, rf_raddr_o
  );
endinterface

// File: rtl/iob_regfile_2p_arbiter.sv
// Round-robin sharing of one 2-port register file between N_REQ requesters (one write + one read per cycle).
// Latency: write lands at the edge ending the grant cycle; read data/rdvalid registered, 1 cycle after grant.
// Backpressure: valid/ready per requester; ready is a combinational one-hot grant, all zero while cke_i=0.
//
// Ports: clk_i (rising edge), arst_n_i (async active-low), cke_i (clock enable),
//        bus (iob_regfile_2p_arbiter_if.slave): requester write/read channels and register-file port.
// Option: define IOB_REGFILE_2P_ARBITER_BYPASS_EN to forward same-cycle write data to a read
//         of the same address; otherwise the read returns the register file's old value.
module iob_regfile_2p_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 21
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cke_i,
  iob_regfile_2p_arbiter_if.slave  bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     wptr_q, rptr_q;
  logic              whit, rhit;
  logic [PW-1:0]     wsel, rsel;
  logic [PW-1:0]     wptr_nxt, rptr_nxt;
  logic [N_REQ-1:0]  wgnt, rgnt;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rd_src;
  logic [N_REQ-1:0]  rdvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Winner is the valid requester with the smallest forward distance from ptr
  // (distance wraps modulo N_REQ), i.e. the first one found searching upward from ptr.
  function automatic void rr_pick(input  logic [N_REQ-1:0] vld,
                                  input  logic [PW-1:0]    ptr,
                                  output logic             hit,
                                  output logic [PW-1:0]    sel);
    int best;
    int d;
    hit  = 1'b0;
    sel  = '0;
    best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N_REQ - int'(ptr));
      if (vld[i] && (d < best)) begin
        best = d;
        hit  = 1'b1;
        sel  = PW'(i);
      end
    end
  endfunction

  always_comb begin
    whit = 1'b0;
    wsel = '0;
    rhit = 1'b0;
    rsel = '0;
    rr_pick(bus.req_wvalid_i, wptr_q, whit, wsel);
    rr_pick(bus.req_rvalid_i, rptr_q, rhit, rsel);
  end

  // One-hot grants and the granted requester's fields; all zero without a grant.
  always_comb begin
    wgnt  = '0;
    rgnt  = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cke_i && whit && (wsel == PW'(i))) begin
        wgnt[i] = 1'b1;
        waddr   = bus.req_waddr_i[i*ADDR_W +: ADDR_W];
        wdata   = bus.req_wdata_i[i*DATA_W +: DATA_W];
      end
      if (cke_i && rhit && (rsel == PW'(i))) begin
        rgnt[i] = 1'b1;
        raddr   = bus.req_raddr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Pointer moves to the requester after the winner; a single requester keeps it at 0.
  assign wptr_nxt = (wsel == PW'(N_REQ - 1)) ? '0 : (wsel + PW'(1));
  assign rptr_nxt = (rsel == PW'(N_REQ - 1)) ? '0 : (rsel + PW'(1));

  always_comb begin
`ifdef IOB_REGFILE_2P_ARBITER_BYPASS_EN
    // Only consulted in a read-grant cycle, so raddr is the real read address here.
    rd_src = ((|wgnt) && (waddr == raddr)) ? wdata : bus.rf_rdata_i;
`else
    rd_src = bus.rf_rdata_i;
`endif
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rdvalid_q <= '0;
      rdata_q   <= '0;
    end else if (cke_i) begin
      if (|wgnt) begin
        wptr_q <= wptr_nxt;
      end
      if (|rgnt) begin
        rptr_q    <= rptr_nxt;
        rdvalid_q <= rgnt;
        rdata_q   <= rd_src;
      end else begin
        rdvalid_q <= '0;
      end
    end
  end

  assign bus.req_wready_o  = wgnt;
  assign bus.req_rready_o  = rgnt;
  assign bus.rf_wen_o      = |wgnt;
  assign bus.rf_waddr_o    = waddr;
  assign bus.rf_wdata_o    = wdata;
  assign bus.rf_raddr_o    = raddr;
  assign bus.req_rdvalid_o = rdvalid_q;
  assign bus.req_rdata_o   = rdata_q;

endmodule

// File: tb/tb_iob_regfile_2p_arbiter.sv
// Self-checking bench for iob_regfile_2p_arbiter with N_REQ=2, ADDR_W=3, DATA_W=21.
// A behavioural register file is attached to the rf_* port; a reference model
// (pointers as integers, memory array, expected read response) predicts every output.
module tb_iob_regfile_2p_arbiter;

  localparam int N = 2;

  logic clk;
  logic arst_n;
  logic cke;

  iob_regfile_2p_arbiter_if #(.N_REQ(2), .ADDR_W(3), .DATA_W(21)) bus ();

  iob_regfile_2p_arbiter #(.N_REQ(2), .ADDR_W(3), .DATA_W(21)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .cke_i    (cke),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file: combinational read, write on rising edge
  logic [20:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(posedge clk) if (bus.rf_wen_o) rf_mem[bus.rf_waddr_o] <= bus.rf_wdata_o;
  assign bus.rf_rdata_i = rf_mem[bus.rf_raddr_o];

  // reference model state
  int          m_wptr, m_rptr;
  logic [20:0] m_mem [8];
  logic [1:0]  m_rdv;
  logic [20:0] m_rdata;

  // DUT values sampled inside the grant cycle, used by the directed checks
  logic [1:0]  obs_wready, obs_rready;
  logic        obs_wen;

  int n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // first valid requester searching upward from ptr with wrap, -1 if none
  function automatic int pick(input logic [1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & 2'b01) != 2'b00) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_wptr  = 0;
    m_rptr  = 0;
    m_rdv   = '0;
    m_rdata = '0;
  endtask

  task automatic clear_inputs();
    bus.req_wvalid_i = '0;
    bus.req_waddr_i  = '0;
    bus.req_wdata_i  = '0;
    bus.req_rvalid_i = '0;
    bus.req_raddr_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_rdvalid", 32'(bus.req_rdvalid_o), 32'd0);
    check("rst_rdata",   32'(bus.req_rdata_o),   32'd0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance the model, then check the registered read response after the edge.
  task automatic step(input logic [1:0] wv, input logic [2:0] wa0, input logic [2:0] wa1,
                      input logic [20:0] wd0, input logic [20:0] wd1,
                      input logic [1:0] rv, input logic [2:0] ra0, input logic [2:0] ra1,
                      input logic ce);
    int          wg, rg;
    logic [2:0]  ea_w, ea_r;
    logic [20:0] ed_w, ed_r;
    @(negedge clk);
    cke              = ce;
    bus.req_wvalid_i = wv;
    bus.req_waddr_i  = {wa1, wa0};
    bus.req_wdata_i  = {wd1, wd0};
    bus.req_rvalid_i = rv;
    bus.req_raddr_i  = {ra1, ra0};
    #1;
    wg   = ce ? pick(wv, m_wptr) : -1;
    rg   = ce ? pick(rv, m_rptr) : -1;
    ea_w = (wg == 0) ? wa0 : (wg == 1) ? wa1 : 3'd0;
    ed_w = (wg == 0) ? wd0 : (wg == 1) ? wd1 : 21'd0;
    ea_r = (rg == 0) ? ra0 : (rg == 1) ? ra1 : 3'd0;
    obs_wready = bus.req_wready_o;
    obs_rready = bus.req_rready_o;
    obs_wen    = bus.rf_wen_o;
    check("wready",   32'(bus.req_wready_o), (wg < 0) ? 32'd0 : (32'd1 << wg));
    check("rready",   32'(bus.req_rready_o), (rg < 0) ? 32'd0 : (32'd1 << rg));
    check("rf_wen",   32'(bus.rf_wen_o),     32'(wg >= 0));
    check("rf_waddr", 32'(bus.rf_waddr_o),   32'(ea_w));
    check("rf_wdata", 32'(bus.rf_wdata_o),   32'(ed_w));
    check("rf_raddr", 32'(bus.rf_raddr_o),   32'(ea_r));
    if (rg >= 0) begin
      ed_r = m_mem[ea_r];
`ifdef IOB_REGFILE_2P_ARBITER_BYPASS_EN
      if (wg >= 0 && ea_w == ea_r) ed_r = ed_w;
`endif
      m_rdata = ed_r;
      m_rdv   = 2'(1 << rg);
      m_rptr  = (rg + 1) % N;
    end else if (ce) begin
      m_rdv = '0;
    end
    if (wg >= 0) begin
      m_mem[ea_w] = ed_w;
      m_wptr      = (wg + 1) % N;
    end
    @(posedge clk);
    #1;
    check("rdvalid", 32'(bus.req_rdvalid_o), 32'(m_rdv));
    check("rdata",   32'(bus.req_rdata_o),   32'(m_rdata));
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    arst_n = 1'b0;
    cke    = 1'b1;
    clear_inputs();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    model_reset();

    // reset state
    #3;
    check("reset_rdvalid", 32'(bus.req_rdvalid_o), 32'd0);
    check("reset_rdata",   32'(bus.req_rdata_o),   32'd0);
    check("reset_wready",  32'(bus.req_wready_o),  32'd0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // write req0 addr 3, then read it back through req1
    step(2'b01, 3'd3, 3'd0, 21'h1ABCD, 21'h0, 2'b00, 3'd0, 3'd0, 1'b1);
    check("tp1_wready", 32'(obs_wready), 32'h1);
    check("tp1_wen",    32'(obs_wen),    32'h1);
    step(2'b00, 3'd0, 3'd0, 21'h0, 21'h0, 2'b10, 3'd0, 3'd3, 1'b1);
    check("tp1_rdvalid", 32'(bus.req_rdvalid_o), 32'h2);
    check("tp1_rdata",   32'(bus.req_rdata_o),   32'h1ABCD);

    // round-robin alternation from pointers at 0 (avoids addr 5)
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(2'b11, 3'd1, 3'd2, 21'($urandom), 21'($urandom), 2'b11, 3'd3, 3'd1, 1'b1);
      check("rr_wready", 32'(obs_wready), (c % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rready", 32'(obs_rready), (c % 2 == 0) ? 32'h1 : 32'h2);
    end

    // same-cycle write and read of addr 5 (still 0)
    step(2'b01, 3'd5, 3'd0, 21'h00055, 21'h0, 2'b10, 3'd0, 3'd5, 1'b1);
`ifdef IOB_REGFILE_2P_ARBITER_BYPASS_EN
    check("same_addr_rdata", 32'(bus.req_rdata_o), 32'h00055);
`else
    check("same_addr_rdata", 32'(bus.req_rdata_o), 32'h00000);
`endif

    // clock enable low: nothing granted, read response and pointers held
    step(2'b01, 3'd4, 3'd0, 21'h12345, 21'h0, 2'b10, 3'd0, 3'd4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(2'b11, 3'd6, 3'd7, 21'h1, 21'h2, 2'b11, 3'd6, 3'd7, 1'b0);
      check("cke0_wready",  32'(obs_wready),           32'h0);
      check("cke0_rready",  32'(obs_rready),           32'h0);
      check("cke0_wen",     32'(obs_wen),              32'h0);
      check("cke0_rdvalid", 32'(bus.req_rdvalid_o),    32'h2);
    end
    step(2'b11, 3'd6, 3'd7, 21'h1, 21'h2, 2'b11, 3'd6, 3'd7, 1'b1);
    check("cke1_wready", 32'(obs_wready), 32'h2);
    check("cke1_rready", 32'(obs_rready), 32'h1);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom), 3'($urandom), 3'($urandom), 21'($urandom), 21'($urandom),
           2'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 7) != 0));
    end

    // reset pulsed during a read-grant cycle
    @(negedge clk);
    cke              = 1'b1;
    bus.req_wvalid_i = 2'b00;
    bus.req_rvalid_i = 2'b10;
    bus.req_raddr_i  = {3'd3, 3'd0};
    #1;
    check("mid_rready", 32'(bus.req_rready_o), 32'h2);
    #1;
    arst_n = 1'b0;
    clear_inputs();
    #1;
    check("mid_rst_rdvalid", 32'(bus.req_rdvalid_o), 32'h0);
    check("mid_rst_rdata",   32'(bus.req_rdata_o),   32'h0);
    #1;
    arst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("post_rst_rdvalid", 32'(bus.req_rdvalid_o), 32'h0);
    step(2'b11, 3'd0, 3'd1, 21'h7, 21'h8, 2'b11, 3'd0, 3'd1, 1'b1);
    check("post_rst_wready", 32'(obs_wready), 32'h1);
    check("post_rst_rready", 32'(obs_rready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_regfile_2p_arbiter.md
# iob_regfile_2p_arbiter

Round-robin arbiter that shares one `iob_regfile_2p` instance between `N_REQ` requesters. It has independent write and read arbiters, so each cycle carries at most one write and one read. It drives the register file's write port and read address combinationally, and returns registered read data one cycle after the grant. It sits between client blocks (DMA, CPU-side CSR logic, accelerators) and a shared register file.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥1)
- `ADDR_W`, 3, register-file address width (matches the register file)
- `DATA_W`, 21, register-file data width

Ports:
- `clk_i`  in  1  clock, rising edge
- `arst_n_i`  in  1  reset, asynchronous, active-low
- `cke_i`  in  1  clock enable; low freezes all state and blocks grants
- `req_wvalid_i`  in  N_REQ  write request per requester
- `req_waddr_i`  in  N_REQ*ADDR_W  packed write addresses (requester i at `[i*ADDR_W +: ADDR_W]`)
- `req_wdata_i`  in  N_REQ*DATA_W  packed write data
- `req_wready_o`  out  N_REQ  write grant, one-hot or zero
- `req_rvalid_i`  in  N_REQ  read request per requester
- `req_raddr_i`  in  N_REQ*ADDR_W  packed read addresses
- `req_rready_o`  out  N_REQ  read grant, one-hot or zero
- `req_rdvalid_o`  out  N_REQ  read data valid, one-hot pulse
- `req_rdata_o`  out  DATA_W  read data, shared by all requesters
- `rf_wen_o`  out  1  to register file `wen_i`
- `rf_waddr_o`  out  ADDR_W  to register file `waddr_i`
- `rf_wdata_o`  out  DATA_W  to register file `wdata_i`
- `rf_raddr_o`  out  ADDR_W  to register file `raddr_i`
- `rf_rdata_i`  in  DATA_W  from register file `rdata_o` (combinational read)

## Operation
- A transfer happens when `valid & ready` on a channel in a cycle with `cke_i=1`.
- Write arbiter:
  - State is a priority pointer `wptr` (0..N_REQ-1).
  - The grant goes to the first requester with `wvalid` set, searching from `wptr` upward and wrapping modulo N_REQ.
  - `req_wready_o` is the one-hot grant, computed combinationally from valids and `wptr`.
- `rf_wen_o = cke_i & |req_wready_o`. `rf_waddr_o`/`rf_wdata_o` come from the granted requester's fields; when there is no grant they are 0.
- After a write grant to requester g, `wptr` becomes (g+1) mod N_REQ. With no grant, `wptr` holds.
- Read arbiter:
  - Same scheme with its own pointer `rptr`.
  - `rf_raddr_o` is the granted address, or 0 when there is no grant.
- On a read grant to g:
  - `req_rdata_o` registers `rf_rdata_i`.
  - `req_rdvalid_o` registers one-hot(g).
- Without a read grant in a `cke_i=1` cycle:
  - `req_rdvalid_o` is 0 next cycle.
  - `req_rdata_o` holds its last value.
- Requesters may drop `valid` without a grant (no stickiness). Holding `valid` high guarantees a grant within N_REQ cycles.
- `N_REQ=1`: the pointer is constant 0 and ready equals valid.
- `cke_i=0`:
  - All readies and `rf_wen_o` are 0.
  - Pointers, `req_rdata_o` and `req_rdvalid_o` hold.

## Timing
- Reset values (asynchronous, while `arst_n_i=0`):
  - `wptr`, `rptr` = 0
  - `req_rdvalid_o` = 0, `req_rdata_o` = 0
- Combinational outputs reflect inputs in the same cycle: `req_wready_o`, `req_rready_o`, `rf_*`.
- Write latency: the data is in the register file at the clock edge that ends the grant cycle.
- Read latency: 1 cycle. `rdvalid`/`rdata` are valid in the cycle after the `rready` grant.
- Throughput: one write plus one read per cycle, sustained.
- Same-cycle write and read to the same address: the register file returns the old value (see Configuration).
- Reset asserted mid-operation:
  - Pending read data is discarded.
  - Pointers return to 0.
  - No `rdvalid` is issued after reset is released.

## Configuration
- `IOB_REGFILE_2P_ARBITER_BYPASS_EN` defined: when a write and a read are granted in the same cycle with `rf_waddr_o == rf_raddr_o`, the registered read data is `rf_wdata_o` (new value).
- Macro undefined: the registered read data is always `rf_rdata_i` (old value); no compare logic is present.

## Test plan
All with N_REQ=2, ADDR_W=3, DATA_W=21.
- Write req0 addr 3 data 0x1ABCD, then read req1 addr 3 → `req_wready_o`=01 and `rf_wen_o`=1 in the same cycle; the following cycle `req_rdvalid_o`=10 and `req_rdata_o`=0x1ABCD.
- Both requesters hold `wvalid` for 6 cycles (wptr=0 at start) → `req_wready_o` sequence 01,10,01,10,01,10. Same check on the read channel.
- Addr 5 holds 0; same cycle write addr 5 data 0x00055 and read addr 5 → next cycle `req_rdata_o`=0x00000 with the macro undefined, 0x00055 with it defined.
- Requests held with `cke_i=0` for 3 cycles → readies and `rf_wen_o` stay 0, `req_rdvalid_o` held. With `cke_i=1` again, the grant goes to the requester indicated by the unchanged pointer.
- Read granted to req1, then `arst_n_i` pulsed low before the next edge → `req_rdvalid_o`=00 and `req_rdata_o`=0. After release, simultaneous requests grant req0 first.
